// File: rtl/mem_banked_if.sv
// Request/response bundle for the banked data memory.
// Optional inj_err signal exists only when MEM_BANKED_PARITY_EN is defined.
interface mem_banked_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 21
);
   // Handshake: a request transfers on a rising edge where req_valid & req_ready;
   // the master holds every req_* field stable until then. Reads answer with a
   // one-cycle rd_valid pulse on the cycle after acceptance; there is no backpressure.
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_W-1:0]     req_addr;
   logic [DATA_W/8-1:0]   req_be;
   logic [DATA_W-1:0]     req_wdata;
   logic                  rd_valid;
   logic [DATA_W-1:0]     rd_data;
   logic                  rd_err;
`ifdef MEM_BANKED_PARITY_EN
   logic                  inj_err;
`endif

   modport master (
      output req_valid, req_we, req_addr, req_be, req_wdata,
`ifdef MEM_BANKED_PARITY_EN
      output inj_err,
`endif
      input  req_ready, rd_valid, rd_data, rd_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_be, req_wdata,
`ifdef MEM_BANKED_PARITY_EN
      input  inj_err,
`endif
      output req_ready, rd_valid, rd_data, rd_err
   );
endinterface

// File: rtl/mem_banked.sv
// Banked synchronous data memory with byte enables, one-cycle read response and a
// post-reset clear sweep. Define MEM_BANKED_PARITY_EN for per-byte even parity.
module mem_banked #(
   parameter int DATA_W    = 32,
   parameter int NUM_BANKS = 8,
   parameter int BANK_AW   = 18
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   output logic         busy,
   output logic         dbg_state,
   mem_banked_if.slave  bus
);
   localparam int SEL_W  = $clog2(NUM_BANKS);
   localparam int ADDR_W = BANK_AW + SEL_W;
   localparam int NB     = DATA_W / 8;
   localparam int DEPTH  = 1 << BANK_AW;

   typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

   state_t               state, state_nxt;
   logic [BANK_AW-1:0]   cnt, cnt_nxt;
   logic                 req_ready;
   logic                 rd_en, wr_en;
   logic [SEL_W-1:0]     bank_sel, sel_q;
   logic [BANK_AW-1:0]   word_addr;
   logic                 rd_valid_q;
   logic [DATA_W-1:0]    bank_rd  [NUM_BANKS];
   logic                 bank_err [NUM_BANKS];

   assign bank_sel  = bus.req_addr[ADDR_W-1:BANK_AW];
   assign word_addr = bus.req_addr[BANK_AW-1:0];
   assign rd_en     = bus.req_valid & req_ready & ~bus.req_we;
   assign wr_en     = bus.req_valid & req_ready &  bus.req_we;
   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      busy      = 1'b0;
      req_ready = 1'b0;
      case (state)
         CLEAR: begin
            busy = 1'b1;
            // clr restarts the sweep; otherwise the last word hands over to IDLE
            if (!clr) begin
               cnt_nxt = cnt + 1'b1;
               if (cnt == {BANK_AW{1'b1}}) state_nxt = IDLE;
            end
         end
         IDLE: begin
            req_ready = ~clr;
            if (clr) state_nxt = CLEAR;
         end
         default: state_nxt = CLEAR;
      endcase
   end

   assign bus.req_ready = req_ready;

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      logic [DATA_W-1:0]  mem [DEPTH];
      logic               hit;
      logic               we;
      logic [BANK_AW-1:0] waddr;
      logic [NB-1:0]      be;
      logic [DATA_W-1:0]  wdata;
      logic [DATA_W-1:0]  q;

      assign hit   = (bank_sel == SEL_W'(g));
      assign we    = busy | (wr_en & hit);
      assign waddr = busy ? cnt : word_addr;
      assign be    = busy ? {NB{1'b1}} : bus.req_be;
      assign wdata = busy ? '0 : bus.req_wdata;

      always_ff @(posedge clk) begin
         if (we) begin
            for (int b = 0; b < NB; b++) begin
               if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)            q <= '0;
         else if (rd_en && hit) q <= mem[word_addr];
      end

      assign bank_rd[g] = q;

`ifdef MEM_BANKED_PARITY_EN
      logic [NB-1:0] par [DEPTH];
      logic [NB-1:0] rd_par;
      logic          inj;
      logic          perr_q;

      assign inj = busy ? 1'b0 : bus.inj_err;

      always_ff @(posedge clk) begin
         if (we) begin
            for (int b = 0; b < NB; b++) begin
               if (be[b]) par[waddr][b] <= (^wdata[8*b +: 8]) ^ inj;
            end
         end
      end

      always_comb begin
         rd_par = '0;
         for (int b = 0; b < NB; b++) rd_par[b] = ^mem[word_addr][8*b +: 8];
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)            perr_q <= 1'b0;
         else if (rd_en && hit) perr_q <= |(par[word_addr] ^ rd_par);
      end

      assign bank_err[g] = perr_q;
`else
      assign bank_err[g] = 1'b0;
`endif
   end

   // The selected bank register only changes on a read of that bank, so
   // rd_data holds between responses without a separate output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_q <= 1'b0;
         sel_q      <= '0;
      end else begin
         rd_valid_q <= rd_en;
         if (rd_en) sel_q <= bank_sel;
      end
   end

   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = bank_rd[sel_q];
   assign bus.rd_err   = bank_err[sel_q];
endmodule

// File: doc/mem_banked.md
# mem_banked

Parametrised banked data memory, the next-generation data store behind the MIPS load/store unit. It provides NUM_BANKS synchronous banks of BANK_DEPTH words each, with bank selection on the upper address bits and per-byte write enables. Accesses use a valid/ready request handshake with a registered one-cycle read response. A post-reset clear sequencer zeroes every word before the first access is accepted.

## Interface
- DATA_W, 32, word width in bits; multiple of 8.
- NUM_BANKS, 8, number of banks; power of 2, at least 2.
- BANK_AW, 18, word-address width inside one bank; BANK_DEPTH = 2^BANK_AW.
- ADDR_W, derived, BANK_AW + log2(NUM_BANKS); not overridable.

- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous request to restart the clear sweep.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address; [ADDR_W-1:BANK_AW] selects the bank, [BANK_AW-1:0] selects the word.
- req_be  in  DATA_W/8  byte enables for writes; ignored on reads.
- req_wdata  in  DATA_W  write data.
- rd_valid  out  1  one-cycle pulse; rd_data is valid.
- rd_data  out  DATA_W  read data; holds its value until the next rd_valid.
- rd_err  out  1  parity error flag, qualified by rd_valid.
- busy  out  1  clear sweep in progress.

## Operation
- FSM has two states, CLEAR and IDLE. Reset enters CLEAR with the sweep counter at 0.
- CLEAR:
  - All banks write 0 to word counter[BANK_AW-1:0] in parallel, with all bytes enabled.
  - The counter increments every cycle.
  - When the counter reaches BANK_DEPTH-1, the FSM moves to IDLE on the next edge.
  - busy = 1 and req_ready = 0.
- IDLE:
  - busy = 0.
  - req_ready = !clr.
  - clr = 1 moves the FSM to CLEAR with the counter at 0.
- A request is accepted when req_valid & req_ready. Exactly one access is made per cycle, to exactly one bank.
- Write:
  - Byte b of the addressed word is updated from req_wdata[8b+7:8b] only where req_be[b] = 1.
  - Other bytes and other banks are untouched.
  - Writes produce no response.
- Read:
  - The addressed word is captured into rd_data at the accepting edge.
  - rd_valid = 1 for the following cycle only.
- A read accepted in the cycle after a write to the same address returns the newly written bytes. There is no stale window.
- req_valid with req_ready = 0 has no effect. The requester holds the request until it is accepted.
- Bank decode is full (power-of-2 bank count), so no out-of-range addresses exist.

## Timing
- Reset values:
  - FSM = CLEAR, counter = 0.
  - req_ready = 0, busy = 1.
  - rd_valid = 0, rd_data = 0, rd_err = 0.
- Clear duration is BANK_DEPTH cycles from reset release or from clr sampled high. req_ready first rises in cycle BANK_DEPTH after the sweep starts.
- Read latency is 1 cycle: request accepted at edge N, so rd_valid/rd_data are valid between edge N and edge N+1.
- Back-to-back reads give one rd_valid per cycle.
- No response backpressure exists. The consumer must take rd_data in the rd_valid cycle.
- clr high in the same cycle as req_valid: the request is not accepted (req_ready = 0) and the sweep starts.
- clr high during CLEAR restarts the counter at 0.
- rst_n low mid-sweep or mid-read:
  - rd_valid drops immediately.
  - The sweep restarts from 0 after release.
- Memory contents are not defined as reset; only the sweep zeroes them.

## Configuration
- MEM_BANKED_PARITY_EN defined:
  - Each byte stores an extra even-parity bit, written with that byte's enable.
  - On a read, rd_err = 1 if any byte's stored parity mismatches its data.
  - The clear sweep writes correct parity (0).
  - An extra input inj_err (1 bit) inverts the stored parity of every enabled byte of an accepted write, for testing.
- Not defined:
  - No parity storage.
  - rd_err is tied to 0.
  - Port inj_err does not exist.

## Test plan
- Reset release:
  - busy = 1 and req_ready = 0 for exactly BANK_DEPTH cycles, then ready = 1.
  - A read of 0x000000 returns 0 with rd_valid one cycle after acceptance.
- Bank walk:
  - Write 0xA5000000+i to word 5 of bank i, for i = 0..7.
  - Read each back: value 0xA5000000+i, with no cross-bank corruption.
- Byte enables:
  - Write 0xFFFFFFFF, then 0x12345678 with be = 4'b0101.
  - Read returns 0xFF34FF78.
- Write then read of the same address in consecutive cycles returns the new data. Four back-to-back reads give four consecutive rd_valid pulses.
- clr asserted together with req_valid:
  - The request is not accepted and busy = 1.
  - After the sweep, previously written words read 0.
- With MEM_BANKED_PARITY_EN:
  - Write with inj_err = 1, then read: rd_err = 1.
  - Rewrite without inj_err, then read: rd_err = 0.
